// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch PC sequencer: operation encoding and priority decode.
// Latency: none (types and a pure function).
// Backpressure: none; stall only suppresses the sequential advance.
package pc_seq_pkg;

    // What the sequencer does to pc and the return stack this cycle
    typedef enum logic [2:0] {
        OP_SEQ,     // advance by INC
        OP_HOLD,    // keep pc (stall with no request)
        OP_REDIR,   // branch/jump: load target, stack untouched
        OP_CALL,    // load target, push link
        OP_RET,     // load popped top (or target when empty)
        OP_SWAP     // call+ret together: load target, replace top with link
    } op_t;

    // Priority: redirect > call/ret (swap when both) > stall > sequential.
    // Reset is not part of the decode; it overrides everything at the registers.
    function automatic op_t decode_op(input logic stall,
                                      input logic redirect,
                                      input logic call,
                                      input logic ret);
        op_t op;
        if (redirect)
            op = OP_REDIR;
        else if (call && ret)
            op = OP_SWAP;
        else if (call)
            op = OP_CALL;
        else if (ret)
            op = OP_RET;
        else if (stall)
            op = OP_HOLD;
        else
            op = OP_SEQ;
        return op;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating count and overflow/underflow pulses.
// Latency: push/pop/replace take effect on the next rising edge; top is a combinational read.
// Backpressure: none; a push while full overwrites the oldest entry, a pop while empty is flagged and ignored.
module ras_stack #(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         replace,
    input  logic [ADDR_W-1:0]            din,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(RAS_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W-1:0]  push_ptr;
    logic              full;
    logic              empty;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    // Depth is a power of two, so the pointer wraps naturally; when full the
    // slot above the top is the oldest entry, which a push overwrites.
    assign push_ptr = top_ptr + PTR_ONE;
    assign top      = mem[top_ptr];

    // Pointer and count: push advances (count saturates), pop retreats unless empty
    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push) begin
            top_ptr <= push_ptr;
            if (!full)
                count <= count + CNT_ONE;
        end else if (pop && !empty) begin
            top_ptr <= top_ptr - PTR_ONE;
            count   <= count - CNT_ONE;
        end
    end

    // Entry storage: contents need no reset, validity is tracked by count
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push)
                mem[push_ptr] <= din;
            else if (replace)
                mem[top_ptr] <= din;
        end
    end

    // Registered one-cycle error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push && full;
            underflow <= pop && !push && empty;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC unit: sequential advance, redirect, call/return through a circular RAS.
// Latency: a request sampled on edge N is visible on pc right after edge N.
// Backpressure: stall only holds the sequential advance; redirect/call/ret/rst always act.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                INC       = 1,
    parameter int                RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic                        call,
    input  logic                        ret,
    input  logic [ADDR_W-1:0]           target,
    output logic [ADDR_W-1:0]           pc,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        ras_underflow
);

    localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

    op_t               op;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_replace;

    assign op        = decode_op(stall, redirect, call, ret);
    assign pc_inc    = pc + INC_W;    // wraps modulo 2^ADDR_W; also the link address
    assign ras_empty = (ras_count == '0);

    // Next-PC mux and stack commands for the decoded operation
    always_comb begin
        pc_nxt      = pc;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_replace = 1'b0;
        unique case (op)
            OP_SEQ:   pc_nxt = pc_inc;
            OP_HOLD:  pc_nxt = pc;
            OP_REDIR: pc_nxt = target;
            OP_CALL: begin
                pc_nxt   = target;
                ras_push = 1'b1;
            end
            OP_RET: begin
                // Empty stack falls back to target; the stack reports the underflow
                pc_nxt  = ras_empty ? target : ras_top;
                ras_pop = 1'b1;
            end
            OP_SWAP: begin
                // Coroutine swap rewrites the top in place; an empty stack gets a plain push
                pc_nxt      = target;
                ras_push    = ras_empty;
                ras_replace = !ras_empty;
            end
            default:  pc_nxt = pc;
        endcase
    end

    // Architectural PC register
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else
            pc <= pc_nxt;
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .replace   (ras_replace),
        .din       (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue-based reference model.
// The model keeps the return stack as a queue of link addresses, dropping the oldest on overflow.
module tb_pc_sequencer;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RST_PC   = 16'h0100;

    bit          clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic        call;
    logic        ret;
    logic [15:0] target;
    logic [15:0] pc;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_link;
    logic [15:0] m_ras[$];
    logic        m_ovf;
    logic        m_unf;

    pc_sequencer #(
        .ADDR_W    (16),
        .RESET_PC  (RST_PC),
        .INC       (1),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .call          (call),
        .ret           (ret),
        .target        (target),
        .pc            (pc),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: evaluated from the rules on every rising edge
    always @(posedge clk) begin
        m_link = m_pc + 16'd1;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        if (rst) begin
            m_pc = RST_PC;
            m_ras.delete();
        end else if (redirect) begin
            m_pc = target;
        end else if (call && ret) begin
            if (m_ras.size() == 0)
                m_ras.push_back(m_link);
            else
                m_ras[m_ras.size()-1] = m_link;
            m_pc = target;
        end else if (call) begin
            m_ras.push_back(m_link);
            if (m_ras.size() > DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1'b1;
            end
            m_pc = target;
        end else if (ret) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = target;
                m_unf = 1'b1;
            end
        end else if (!stall) begin
            m_pc = m_pc + 16'd1;
        end
    end

    // Compare process: outputs are stable at the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pc",        {16'h0, pc},            {16'h0, m_pc});
            chk("model_ras_count", {29'h0, ras_count},     32'(m_ras.size()));
            chk("model_overflow",  {31'h0, ras_overflow},  {31'h0, m_ovf});
            chk("model_underflow", {31'h0, ras_underflow}, {31'h0, m_unf});
        end
    end

    // Drive one cycle's inputs (called at a falling edge), then wait for the next falling edge
    task automatic cyc(input logic r, input logic s, input logic rd, input logic c,
                       input logic rt, input logic [15:0] t);
        rst      = r;
        stall    = s;
        redirect = rd;
        call     = c;
        ret      = rt;
        target   = t;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [15:0] exp_pc, input logic [2:0] exp_cnt);
        chk({name, "_pc"},  {16'h0, pc},        {16'h0, exp_pc});
        chk({name, "_cnt"}, {29'h0, ras_count}, {29'h0, exp_cnt});
    endtask

    initial begin
        rst = 1; stall = 0; redirect = 0; call = 1; ret = 0; target = 16'h1234;
        m_pc = 16'h0; m_link = 16'h0; m_ovf = 0; m_unf = 0;
        // Reset held with a call pending: the call must be discarded
        repeat (2) @(negedge clk);
        chk_en = 1;
        lit("reset", 16'h0100, 3'd0);
        chk("reset_ovf", {31'h0, ras_overflow},  32'h0);
        chk("reset_unf", {31'h0, ras_underflow}, 32'h0);

        // Free-running advance, then stall
        cyc(0, 0, 0, 0, 0, 16'h0); lit("seq1", 16'h0101, 3'd0);
        cyc(0, 0, 0, 0, 0, 16'h0); lit("seq2", 16'h0102, 3'd0);
        cyc(0, 0, 0, 0, 0, 16'h0); lit("seq3", 16'h0103, 3'd0);
        cyc(0, 1, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 0, 16'h0); lit("stall", 16'h0103, 3'd0);

        // Redirect under stall wins over call+ret and leaves the stack alone
        cyc(0, 0, 0, 1, 0, 16'h0200); lit("pre_call", 16'h0200, 3'd1);
        cyc(0, 1, 1, 1, 1, 16'h2000); lit("redir_stall", 16'h2000, 3'd1);
        cyc(0, 0, 0, 0, 1, 16'h0777); lit("redir_ras_kept", 16'h0104, 3'd0);

        // Nested call/return
        cyc(0, 0, 1, 0, 0, 16'h0010);
        cyc(0, 0, 0, 1, 0, 16'h0400); lit("call1", 16'h0400, 3'd1);
        cyc(0, 0, 0, 1, 0, 16'h0800); lit("call2", 16'h0800, 3'd2);
        cyc(0, 0, 0, 0, 1, 16'h0777); lit("ret1",  16'h0401, 3'd1);
        cyc(0, 0, 0, 0, 1, 16'h0777); lit("ret2",  16'h0011, 3'd0);

        // Five calls into a 4-deep stack: oldest link (0x0012) is lost
        cyc(0, 0, 0, 1, 0, 16'h1000);
        cyc(0, 0, 0, 1, 0, 16'h1100);
        cyc(0, 0, 0, 1, 0, 16'h1200);
        cyc(0, 0, 0, 1, 0, 16'h1300); lit("call4", 16'h1300, 3'd4);
        chk("no_ovf_4th", {31'h0, ras_overflow}, 32'h0);
        cyc(0, 0, 0, 1, 0, 16'h1400); lit("call5", 16'h1400, 3'd4);
        chk("ovf_5th", {31'h0, ras_overflow}, 32'h1);
        cyc(0, 0, 0, 0, 1, 16'h0777); lit("ovf_ret1", 16'h1301, 3'd3);
        chk("ovf_pulse_end", {31'h0, ras_overflow}, 32'h0);
        cyc(0, 0, 0, 0, 1, 16'h0777); lit("ovf_ret2", 16'h1201, 3'd2);
        cyc(0, 0, 0, 0, 1, 16'h0777); lit("ovf_ret3", 16'h1101, 3'd1);
        cyc(0, 0, 0, 0, 1, 16'h0777); lit("ovf_ret4", 16'h1001, 3'd0);

        // Return on empty stack uses target and pulses underflow once
        cyc(0, 0, 0, 0, 1, 16'h0555); lit("unf", 16'h0555, 3'd0);
        chk("unf_pulse", {31'h0, ras_underflow}, 32'h1);
        cyc(0, 0, 0, 0, 0, 16'h0);    lit("unf_after", 16'h0556, 3'd0);
        chk("unf_pulse_end", {31'h0, ras_underflow}, 32'h0);

        // Coroutine swap: top 0x0010 replaced by 0x0041
        cyc(0, 0, 1, 0, 0, 16'h000F);
        cyc(0, 0, 0, 1, 0, 16'h0040); lit("swap_setup", 16'h0040, 3'd1);
        cyc(0, 0, 0, 1, 1, 16'h0080); lit("swap", 16'h0080, 3'd1);
        cyc(0, 0, 0, 0, 1, 16'h0777); lit("swap_ret", 16'h0041, 3'd0);
        // Swap on empty stack behaves as a plain call
        cyc(0, 0, 0, 1, 1, 16'h0300); lit("swap_empty", 16'h0300, 3'd1);
        cyc(0, 0, 0, 0, 1, 16'h0777); lit("swap_empty_ret", 16'h0042, 3'd0);

        // Address wrap
        cyc(0, 0, 1, 0, 0, 16'hFFFF); lit("wrap_pre", 16'hFFFF, 3'd0);
        cyc(0, 0, 0, 0, 0, 16'h0);    lit("wrap", 16'h0000, 3'd0);

        // Reset mid-sequence with a call on the same edge
        cyc(0, 0, 0, 1, 0, 16'h0500); lit("rst_pre", 16'h0500, 3'd1);
        cyc(1, 1, 0, 1, 0, 16'h0600); lit("rst_call", 16'h0100, 3'd0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                16'($urandom()));
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the fetch stage. It holds the architectural fetch PC and advances it by a fixed increment, or redirects it on branch, jump, call and return requests. A circular return-address stack (RAS) supplies return targets. It replaces the fixed 16-bit counter, adding width/reset/increment parameters, call/return sequencing, and stack overflow/underflow reporting.

## Interface
- ADDR_W, 16, PC and target width in bits (≥ 4)
- RESET_PC, 0, PC value loaded by reset
- INC, 1, sequential increment added per advance
- RAS_DEPTH, 4, return-stack entries (power of 2, ≥ 2)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC (suppresses sequential advance only)
- redirect  in  1  branch/jump taken: load target
- call  in  1  jump-and-link: load target, push pc+INC
- ret  in  1  return: load popped RAS top
- target  in  ADDR_W  destination for redirect/call; fallback for ret on empty RAS
- pc  out  ADDR_W  current fetch PC (registered)
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries, 0..RAS_DEPTH
- ras_overflow  out  1  one-cycle pulse: push while full
- ras_underflow  out  1  one-cycle pulse: pop while empty

## Operation
- Next-PC priority, evaluated each cycle: rst > redirect > ret/call > sequential.
- rst: pc←RESET_PC, ras_count←0, pointers cleared, flags←0. Stack contents are don't-care.
- redirect (any call/ret ignored, RAS untouched): pc←target.
- call only: pc←target; push (pc+INC) mod 2^ADDR_W. When full, overwrite the oldest entry (circular), keep ras_count=RAS_DEPTH, and pulse ras_overflow.
- ret only, ras_count>0: pc←top entry; pop.
- ret only, ras_count=0: pc←target; pulse ras_underflow; count stays 0.
- call and ret together (coroutine swap): pc←target and top entry←pc+INC. ras_count is unchanged. If the RAS is empty, act as a plain call.
- None asserted, stall=0: pc←(pc+INC) mod 2^ADDR_W. With stall=1: pc held.
- stall never blocks redirect, call, ret or rst.
- Arithmetic is unsigned, ADDR_W bits, and wraps silently. No carry or flag is produced.

## Timing
- pc is a direct register output. A request sampled at edge N is visible on pc after edge N; zero additional latency.
- ras_overflow and ras_underflow are registered. Each is high for exactly the cycle after the offending edge.
- ras_count updates on the same edge as pc.
- Reset outputs: pc=RESET_PC, ras_count=0, ras_overflow=0, ras_underflow=0.
- Reset asserted mid-sequence discards every pending request on that edge.
- Back-to-back calls and returns are supported every cycle. No bubble is required.

## Structure
- Package pc_seq_pkg holds:
  - op encoding enum {OP_SEQ, OP_HOLD, OP_REDIR, OP_CALL, OP_RET, OP_SWAP}
  - the priority-decode function mapping (stall, redirect, call, ret) to op
- Sub-module ras_stack (params ADDR_W, RAS_DEPTH) contains:
  - circular LIFO with a top pointer and saturating count
  - push, pop and replace ports
  - overflow and underflow outputs
- The top level contains the next-PC mux, the pc register and the op decode.

## Test plan
- Reset and sequence: RESET_PC=0x0100, INC=1, 3 free cycles → pc 0x0100, 0x0101, 0x0102, 0x0103. Then stall for 2 cycles → pc holds 0x0103.
- Redirect under stall: stall=1, redirect=1, target=0x2000 → pc=0x2000 next cycle, RAS unchanged.
- Call/return nesting: at pc=0x0010, call target=0x0400; at 0x0400, call target=0x0800; then ret, ret.
  - pc goes 0x0400, 0x0800, 0x0401, 0x0011.
  - ras_count goes 1, 2, 1, 0.
- Overflow: RAS_DEPTH=4, five consecutive calls → ras_overflow pulses once on the 5th call and ras_count=4. Then four rets → pops return entries 5, 4, 3, 2; the oldest entry is lost.
- Underflow: ras_count=0, ret with target=0x0555 → pc=0x0555, ras_underflow=1 for one cycle.
- Wrap and simultaneous events:
  - ADDR_W=8, pc=0xFF, INC=1 → next pc=0x00.
  - call+ret together at pc=0x40, target=0x80, RAS top=0x10 → pc=0x80, top becomes 0x41, count unchanged.
  - rst asserted with a call in the same cycle → pc=RESET_PC, count=0.
